// File: rtl/excess3_to_bcd_deser_if.sv
// Digit-in / word-out bundle for the excess-3 to BCD deserialiser.
// The master drives digits and out_ready; the slave (the deserialiser) drives the rest.
interface excess3_to_bcd_deser_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_exe;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_err;
  logic [3:0]            out_cnt;

  modport master (
    output in_valid, in_exe, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_err, out_cnt
  );

  modport slave (
    input  in_valid, in_exe, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_err, out_cnt
  );
endinterface

// File: rtl/excess3_to_bcd_deser.sv
// Decodes a stream of excess-3 digits (MS digit first) and packs them into BCD words.
// Words close after DIGITS digits or early on in_last; an illegal code zeroes its digit and flags the word.
module excess3_to_bcd_deser #(
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  excess3_to_bcd_deser_if.slave      bus,
  output logic                       dbg_state
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                run;
  logic [4*DIGITS-1:0] acc;
  logic [3:0]          cnt;
  logic                err;
  logic                illegal;
  logic [3:0]          digit;
  logic                in_rdy;
  logic                in_fire;
  logic                out_fire;

  // Handshake: a beat transfers on any rising edge where valid && ready are both high;
  // valid without ready has no effect and the source holds its data. in_ready depends
  // only on registered state, so there is no path from out_ready or in_* to in_ready.

  always_comb begin
    illegal = (bus.in_exe < 4'd3) || (bus.in_exe > 4'd12);
    digit   = illegal ? 4'h0 : (bus.in_exe - 4'd3);
  end

  assign in_fire  = bus.in_valid && in_rdy;
  assign out_fire = (state == HOLD) && bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && (bus.in_last || (cnt == LAST_IDX))) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    in_rdy        = run && (state == COLLECT);
    bus.in_ready  = in_rdy;
    bus.out_valid = (state == HOLD);
    bus.out_bcd   = acc;
    bus.out_cnt   = cnt;
    bus.out_err   = err;
    dbg_state     = state;
  end

  // Word accumulator; cleared as the held word leaves so short words read zero-extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= 4'd0;
      err <= 1'b0;
    end else if (out_fire) begin
      acc <= '0;
      cnt <= 4'd0;
      err <= 1'b0;
    end else if (in_fire) begin
      acc <= {acc[4*DIGITS-5:0], digit};
      cnt <= cnt + 4'd1;
      err <= err | illegal;
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_deser.sv
// Directed bench for excess3_to_bcd_deser (DIGITS=4) with immediate-assertion checks.
module tb_excess3_to_bcd_deser;

  logic clk;
  logic rst_n;
  logic dbg_state;
  int   checks;
  int   failures;

  excess3_to_bcd_deser_if #(.DIGITS(4)) bus ();

  excess3_to_bcd_deser #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one digit and hold it until accepted (bounded), return #1 after the accepting edge.
  task automatic send(input logic [3:0] e, input logic l);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_exe   = e;
    bus.in_last  = l;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("send_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Check the held word, then take it and confirm out_valid drops.
  task automatic recv(input string tag, input logic [15:0] b, input logic [3:0] c, input logic e);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_bcd"},   {16'd0, bus.out_bcd},   {16'd0, b});
    check({tag, "_cnt"},   {28'd0, bus.out_cnt},   {28'd0, c});
    check({tag, "_err"},   {31'd0, bus.out_err},   {31'd0, e});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop"},  {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_bcd;
    logic        exp_err;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_exe    = 4'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_bcd",   {16'd0, bus.out_bcd},   32'd0);
    check("rst_out_cnt",   {28'd0, bus.out_cnt},   32'd0);
    check("rst_out_err",   {31'd0, bus.out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1: full word back-to-back
    send(4'h4, 1'b0);
    send(4'h8, 1'b0);
    send(4'hC, 1'b0);
    send(4'h3, 1'b0);
    recv("t1", 16'h1590, 4'd4, 1'b0);

    // 2: one-digit sweep over all codes
    for (int i = 0; i < 16; i++) begin
      exp_err = (i < 3) || (i > 12);
      exp_bcd = exp_err ? 16'h0000 : 16'(i - 3);
      send(4'(i), 1'b1);
      recv($sformatf("t2_%0d", i), exp_bcd, 4'd1, exp_err);
    end

    // 3: early close, then no stale digits
    send(4'h6, 1'b0);
    send(4'h9, 1'b1);
    recv("t3a", 16'h0036, 4'd2, 1'b0);
    send(4'h5, 1'b0);
    send(4'h5, 1'b0);
    send(4'h5, 1'b0);
    send(4'h5, 1'b0);
    recv("t3b", 16'h2222, 4'd4, 1'b0);

    // 4: sticky error, then clean word; in_last on the 4th digit changes nothing
    send(4'h4, 1'b0);
    send(4'hF, 1'b0);
    send(4'h7, 1'b0);
    send(4'h3, 1'b0);
    recv("t4a", 16'h1040, 4'd4, 1'b1);
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b1);
    recv("t4b", 16'h0001, 4'd4, 1'b0);

    // 5: backpressure with a digit waiting
    send(4'h4, 1'b0);
    send(4'h8, 1'b0);
    send(4'hC, 1'b0);
    send(4'h3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_exe   = 4'h9;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t5_in_ready", {31'd0, bus.in_ready},  32'd0);
      check("t5_valid",    {31'd0, bus.out_valid}, 32'd1);
      check("t5_bcd",      {16'd0, bus.out_bcd},   32'h1590);
      check("t5_cnt",      {28'd0, bus.out_cnt},   32'd4);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t5_drop",  {31'd0, bus.out_valid}, 32'd0);
    check("t5_ready", {31'd0, bus.in_ready},  32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t5_first_cnt", {28'd0, bus.out_cnt}, 32'd1);
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    recv("t5b", 16'h6000, 4'd4, 1'b0);

    // 6: reset mid-word
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    check("t6_partial_cnt", {28'd0, bus.out_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_bcd",   {16'd0, bus.out_bcd},   32'd0);
    check("t6_rst_cnt",   {28'd0, bus.out_cnt},   32'd0);
    check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_rst_ready", {31'd0, bus.in_ready},  32'd0);
    check("t6_rst_state", {31'd0, dbg_state},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_post_ready", {31'd0, bus.in_ready}, 32'd1);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    recv("t6", 16'h0123, 4'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
